// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO controller: FSM encoding, op codes,
// watchdog defaults.
`timescale 1ns/1ps
package hilo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN_MULT = 3'd1,
    ST_RUN_DIV  = 3'd2,
    ST_CAPTURE  = 3'd3,
    ST_EXCP     = 3'd4
  } hilo_state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int unsigned TIMEOUT_DEFAULT = 64;

  // Watchdog counter width: wide enough to hold TIMEOUT-1, never below 7 bits.
  function automatic int unsigned wd_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout) + 1;
    return (w < 7) ? 7 : w;
  endfunction

endpackage

// File: rtl/hilo_watchdog.sv
// Saturating cycle counter that flags when a unit has run TIMEOUT-1 cycles.
`timescale 1ns/1ps
module hilo_watchdog
  import hilo_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned W       = wd_width(TIMEOUT)
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, increment saturates at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO register controller: sequences the multiply/divide units, captures
// their results into HI/LO, handles mthi/mtlo moves, div-by-zero and timeout.
`timescale 1ns/1ps
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  output logic        multCtrl,
  output logic        divCtrl,
  input  logic        multDone,
  input  logic        divDone,
  input  logic        div0,
  input  logic [31:0] MultHIOut,
  input  logic [31:0] MultLOOut,
  input  logic [31:0] DivHIOut,
  input  logic [31:0] DivLOOut,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] RegAOut,
  output logic [31:0] HIOut,
  output logic [31:0] LOOut,
  output logic        busy,
  output logic        done,
  output logic        excpDiv0,
  output logic        excpTimeout
);

  hilo_state_t state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        cause_div0_q, cause_div0_d;
  logic        wd_clr;
  logic        wd_inc;
  logic        wd_expired;

  hilo_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clr     (wd_clr),
    .inc     (wd_inc),
    .expired (wd_expired)
  );

  // Next-state, HI/LO update and watchdog control.
  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    cause_div0_d = cause_div0_q;
    wd_clr       = 1'b0;
    wd_inc       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mthi) hi_d = RegAOut;
        if (mtlo) lo_d = RegAOut;
        if (start) begin
          wd_clr  = 1'b1;
          state_d = (op == OP_DIV) ? ST_RUN_DIV : ST_RUN_MULT;
        end
      end
      ST_RUN_MULT: begin
        if (multDone) begin
          hi_d    = MultHIOut;
          lo_d    = MultLOOut;
          state_d = ST_CAPTURE;
        end else if (wd_expired) begin
          cause_div0_d = 1'b0;
          state_d      = ST_EXCP;
        end else begin
          wd_inc = 1'b1;
        end
      end
      ST_RUN_DIV: begin
        if (divDone) begin
          if (div0) begin
            cause_div0_d = 1'b1;
            state_d      = ST_EXCP;
          end else begin
            hi_d    = DivHIOut;
            lo_d    = DivLOOut;
            state_d = ST_CAPTURE;
          end
        end else if (wd_expired) begin
          cause_div0_d = 1'b0;
          state_d      = ST_EXCP;
        end else begin
          wd_inc = 1'b1;
        end
      end
      ST_CAPTURE: state_d = ST_IDLE;
      ST_EXCP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State, HI/LO and exception-cause registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hi_q         <= '0;
      lo_q         <= '0;
      cause_div0_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      cause_div0_q <= cause_div0_d;
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    multCtrl    = (state_q == ST_RUN_MULT);
    divCtrl     = (state_q == ST_RUN_DIV);
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_CAPTURE);
    excpDiv0    = (state_q == ST_EXCP) &&  cause_div0_q;
    excpTimeout = (state_q == ST_EXCP) && !cause_div0_q;
  end

  assign HIOut = hi_q;
  assign LOOut = lo_q;

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 64, is the max cycles waited for a unit's done before abort.
REQ-002 clock  in  1  single clock; all state on posedge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 start  in  1  one-cycle command pulse; sampled only in IDLE.
REQ-005 op  in  1  0 = MULT, 1 = DIV; sampled with start.
REQ-006 multCtrl / divCtrl  out  1 each  held high while the matching unit runs.
REQ-007 multDone / divDone  in  1 each  unit completion flags.
REQ-008 div0  in  1  divider zero-divisor flag, valid with divDone.
REQ-009 MultHIOut, MultLOOut, DivHIOut, DivLOOut  in  32 each  unit results.
REQ-010 mthi / mtlo  in  1 each  direct write of RegAOut into HI / LO.
REQ-011 RegAOut  in  32  write data for mthi/mtlo.
REQ-012 HIOut / LOOut  out  32 each  architectural HI / LO registers.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 done  out  1  one-cycle pulse on successful capture.
REQ-015 excpDiv0 / excpTimeout  out  1 each  one-cycle exception pulses.

Function
REQ-016 States: IDLE, RUN_MULT, RUN_DIV, CAPTURE, EXCP; 3-bit encoding.
REQ-017 IDLE + start: op=0 -> RUN_MULT, op=1 -> RUN_DIV; watchdog counter cleared to 0.
REQ-018 multCtrl is high exactly in RUN_MULT, divCtrl exactly in RUN_DIV; both low in every other state, so a unit always sees ctrl low at least one cycle between operations.
REQ-019 RUN_x + xDone=1 (and div0=0 for DIV) -> CAPTURE; HI/LO load the unit's HI/LO outputs on that same edge.
REQ-020 RUN_DIV + divDone=1 + div0=1 -> EXCP; HI/LO unchanged; excpDiv0 pulses in EXCP.
REQ-021 RUN_x, done flag low: counter increments; counter reaching TIMEOUT-1 -> EXCP with excpTimeout, HI/LO unchanged.
REQ-022 CAPTURE: done pulses high one cycle, then -> IDLE.
REQ-023 EXCP: lasts exactly one cycle, then -> IDLE.
REQ-024 Latency: done rises 1 cycle after the edge that samples xDone; minimum start-to-done 3 cycles.
REQ-025 start while busy is ignored (not queued).
REQ-026 mthi/mtlo act only in IDLE; ignored while busy; both together write both registers.
REQ-027 start and mthi/mtlo in the same IDLE cycle: the move is written, the operation also starts, its capture later overwrites.
REQ-028 Done flag of the non-selected unit is ignored.
REQ-029 Counter is 7 bits minimum, saturates, never wraps.

Reset
REQ-030 Reset, asynchronous at any time, including mid-operation, forces IDLE, HIOut=LOOut=0, counter=0, and all control/pulse outputs to 0.
REQ-031 After reset deasserts, the first start is accepted on the first posedge.

Structure
REQ-032 State encoding, op codes and TIMEOUT default live in shared package hilo_pkg.
REQ-033 Single module; optional sub-module hilo_watchdog holds the counter.
REQ-034 No arithmetic is performed here; results pass through unmodified.

Verification
REQ-035 DIV 100/7, divider done after 5 cycles -> HI=2, LO=14, done pulse, divCtrl then low.
REQ-036 DIV with div0=1 on done -> excpDiv0 pulse, HI/LO keep prior values 0x11/0x22.
REQ-037 MULT, multDone never asserted, TIMEOUT=64 -> excpTimeout 64 cycles after start, IDLE next cycle.
REQ-038 mthi RegAOut=0xDEADBEEF in IDLE -> HI=0xDEADBEEF; repeat while busy -> HI unchanged.
REQ-039 Reset mid-RUN_DIV -> immediate IDLE, HI=LO=0, divCtrl=0, no done pulse.
REQ-040 Second start while in RUN_MULT -> ignored, single done pulse only.
